// File: rtl/unpack.sv
// Unpacks 32-bit storage words into a stream of 8-bit pixels, byte0 first.
// One word is fetched at a time; a new request is issued only after byte3 has been accepted.
module unpack #(
  parameter int NUM_PIX = 182,
  parameter int WORD_AW = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               word_req,
  output logic [WORD_AW-1:0] word_addr,
  input  logic               word_valid,
  input  logic [31:0]        word_data,
  output logic               pixel_valid,
  input  logic               pix_ready,
  output logic [7:0]         pix_addr,
  output logic [7:0]         out_data,
  output logic               done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [7:0] LAST_PIX = 8'(NUM_PIX - 1);

  logic [1:0]         state_reg;
  logic [1:0]         byte_cnt_reg;
  logic [31:0]        word_reg;
  logic [WORD_AW-1:0] word_addr_reg;
  logic [7:0]         pix_addr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      byte_cnt_reg  <= 2'd0;
      word_reg      <= 32'd0;
      word_addr_reg <= '0;
      pix_addr_reg  <= 8'd0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg     <= S_REQ;
            byte_cnt_reg  <= 2'd0;
            word_addr_reg <= '0;
            pix_addr_reg  <= 8'd0;
          end
        end
        S_REQ: begin
          if (word_valid) begin
            word_reg  <= word_data;
            state_reg <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (pix_ready) begin
            pix_addr_reg <= pix_addr_reg + 8'd1;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            // The final pixel ends the frame even mid-word; leftover bytes are dropped.
            if (pix_addr_reg == LAST_PIX) begin
              state_reg <= S_DONE;
            end else if (byte_cnt_reg == 2'd3) begin
              state_reg     <= S_REQ;
              word_addr_reg <= word_addr_reg + WORD_AW'(1);
            end
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    out_data = word_reg[7:0];
    case (byte_cnt_reg)
      2'd0:    out_data = word_reg[7:0];
      2'd1:    out_data = word_reg[15:8];
      2'd2:    out_data = word_reg[23:16];
      default: out_data = word_reg[31:24];
    endcase
  end

  assign word_req    = (state_reg == S_REQ);
  assign pixel_valid = (state_reg == S_EMIT);
  assign done        = (state_reg == S_DONE);
  assign word_addr   = word_addr_reg;
  assign pix_addr    = pix_addr_reg;

endmodule

// File: tb/tb_unpack.sv
// Bench for unpack: a storage responder and a stream monitor feed per-scenario tasks
// that compare against a frame model built directly from the word memory.
module tb_unpack;
  localparam int NP = 182;
  localparam int AW = 6;
  localparam int NW = (NP + 3) / 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          word_req;
  logic [AW-1:0] word_addr;
  logic          word_valid;
  logic [31:0]   word_data;
  logic          pixel_valid;
  logic          pix_ready;
  logic [7:0]    pix_addr;
  logic [7:0]    out_data;
  logic          done;

  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = 32'd0;
  logic        spur_valid = 1'b0;
  logic        man_ready = 1'b1;
  logic        rnd_ready = 1'b1;
  bit          rand_ready = 1'b0;

  assign word_valid = resp_valid | spur_valid;
  assign word_data  = resp_data;
  assign pix_ready  = rand_ready ? rnd_ready : man_ready;

  unpack #(.NUM_PIX(NP), .WORD_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .word_req(word_req), .word_addr(word_addr),
    .word_valid(word_valid), .word_data(word_data),
    .pixel_valid(pixel_valid), .pix_ready(pix_ready),
    .pix_addr(pix_addr), .out_data(out_data), .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  int  lat_fixed = 0;
  bit  lat_rand = 1'b0;
  int  lat_cur = 0;
  int  wait_cnt = 0;
  bit  in_req = 1'b0;
  int  errors = 0;
  int  checks = 0;

  // Storage model: answers a request after lat_cur cycles with the addressed word.
  always @(negedge clk) begin
    if (word_req) begin
      if (!in_req) begin
        in_req   = 1'b1;
        wait_cnt = 0;
        lat_cur  = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
      end
      if (wait_cnt >= lat_cur) begin
        resp_valid = 1'b1;
        resp_data  = mem[word_addr];
      end else begin
        resp_valid = 1'b0;
        wait_cnt++;
      end
    end else begin
      in_req     = 1'b0;
      resp_valid = 1'b0;
      resp_data  = $urandom;
    end
  end

  always @(negedge clk) rnd_ready = 1'($urandom_range(0, 1));

  logic [7:0] x_addr[$];
  logic [7:0] x_data[$];
  int         x_cycle[$];
  int         acc_addr[$];
  int         acc_cycle[$];
  int         done_count = 0;
  int         done_cycle = 0;
  int         hold_breaks = 0;
  int         cycle = 0;
  bit         hold_pending = 1'b0;
  logic [7:0] h_addr = 8'd0;
  logic [7:0] h_data = 8'd0;

  // Stream monitor: logs what will transfer on the coming rising edge.
  always @(negedge clk) begin
    #1;
    cycle++;
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending && (!pixel_valid || pix_addr !== h_addr || out_data !== h_data))
        hold_breaks++;
      hold_pending = pixel_valid && !pix_ready;
      h_addr = pix_addr;
      h_data = out_data;
      if (pixel_valid && pix_ready) begin
        x_addr.push_back(pix_addr);
        x_data.push_back(out_data);
        x_cycle.push_back(cycle);
      end
      if (word_req && word_valid) begin
        acc_addr.push_back(int'(word_addr));
        acc_cycle.push_back(cycle);
      end
      if (done) begin
        done_count++;
        done_cycle = cycle;
      end
    end
  end

  int xb, ab, db, hb;

  task automatic mark();
    xb = x_addr.size();
    ab = acc_addr.size();
    db = done_count;
    hb = hold_breaks;
  endtask

  function automatic logic [7:0] model_pix(input int i);
    logic [31:0] w;
    w = mem[i / 4];
    return 8'(w >> (8 * (i % 4)));
  endfunction

  function automatic int frame_bad();
    int bad = 0;
    for (int i = 0; i < x_addr.size() - xb; i++)
      if (x_addr[xb+i] !== 8'(i) || x_data[xb+i] !== model_pix(i)) bad++;
    return bad;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0;
    d0 = done_count;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #2;
      if (done_count != d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic fill_random();
    for (int w = 0; w < 64; w++) mem[w] = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    checks++; if (word_req !== 1'b0) begin errors++; $display("FAIL reset_word_req: got %b want 0", word_req); end
    checks++; if (word_addr !== '0) begin errors++; $display("FAIL reset_word_addr: got %0d want 0", word_addr); end
    checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL reset_pixel_valid: got %b want 0", pixel_valid); end
    checks++; if (pix_addr !== 8'd0) begin errors++; $display("FAIL reset_pix_addr: got %0d want 0", pix_addr); end
    checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    checks++; if (word_req !== 1'b0 || pixel_valid !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: word_req=%b pixel_valid=%b want 0 0", word_req, pixel_valid);
    end
    $display("reset: outputs checked during and after reset");
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [4];
    bit ok;
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    fill_random();
    mem[0] = 32'h44332211;
    lat_fixed = 0; lat_rand = 1'b0; rand_ready = 1'b0; man_ready = 1'b1;
    mark();
    pulse_start();
    #2;
    checks++; if (word_req !== 1'b1 || word_addr !== 6'd0 || pixel_valid !== 1'b0) begin
      errors++; $display("FAIL basic_req0: word_req=%b addr=%0d pv=%b want 1 0 0", word_req, word_addr, pixel_valid);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #2;
      checks++; if (pixel_valid !== 1'b1 || pix_addr !== 8'(k) || out_data !== exp_b[k]) begin
        errors++; $display("FAIL basic_pix%0d: pv=%b addr=%0d data=%h want 1 %0d %h", k, pixel_valid, pix_addr, out_data, k, exp_b[k]);
      end
    end
    @(negedge clk);
    #2;
    checks++; if (word_req !== 1'b1 || word_addr !== 6'd1 || pixel_valid !== 1'b0) begin
      errors++; $display("FAIL basic_req1: word_req=%b addr=%0d pv=%b want 1 1 0", word_req, word_addr, pixel_valid);
    end
    wait_done(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done: got timeout want done pulse"); end
    $display("basic: frame of %0d pixels, first word 44332211", x_addr.size() - xb);
  endtask

  task automatic test_full_frame();
    bit ok;
    int span;
    for (int w = 0; w < 64; w++)
      mem[w] = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
    lat_fixed = 0; lat_rand = 1'b0; rand_ready = 1'b0; man_ready = 1'b1;
    mark();
    pulse_start();
    wait_done(3000, ok);
    repeat (3) @(negedge clk);
    #2;
    checks++; if (!ok) begin errors++; $display("FAIL full_done: got timeout want done pulse"); end
    checks++; if (x_addr.size() - xb != NP) begin errors++; $display("FAIL full_count: got %0d want %0d", x_addr.size() - xb, NP); end
    checks++; if (frame_bad() != 0) begin errors++; $display("FAIL full_data: got %0d bad pixels want 0", frame_bad()); end
    checks++; if (acc_addr.size() - ab != NW) begin errors++; $display("FAIL full_words: got %0d want %0d", acc_addr.size() - ab, NW); end
    checks++; if (acc_addr.size() == 0 || acc_addr[$] != NW - 1) begin errors++; $display("FAIL full_last_word: got %0d want %0d", acc_addr.size() ? acc_addr[$] : -1, NW - 1); end
    checks++; if (done_count - db != 1) begin errors++; $display("FAIL full_done_pulses: got %0d want 1", done_count - db); end
    checks++; if (x_cycle.size() == 0 || done_cycle != x_cycle[$] + 1) begin
      errors++; $display("FAIL full_done_timing: got cycle %0d want %0d", done_cycle, x_cycle.size() ? x_cycle[$] + 1 : -1);
    end
    span = (x_cycle.size() > 0 && acc_cycle.size() > ab) ? x_cycle[$] - acc_cycle[ab] : -1;
    checks++; if (span != 5 * (NW - 1) + ((NP - 1) % 4) + 1) begin
      errors++; $display("FAIL full_throughput: got %0d cycles want %0d", span, 5 * (NW - 1) + ((NP - 1) % 4) + 1);
    end
    checks++; if (done !== 1'b0 || word_req !== 1'b0) begin errors++; $display("FAIL full_idle: done=%b word_req=%b want 0 0", done, word_req); end
    $display("full_frame: %0d transfers, %0d words, span %0d cycles", x_addr.size() - xb, acc_addr.size() - ab, span);
  endtask

  task automatic test_backpressure();
    bit ok, found;
    int bad;
    logic [7:0] held;
    fill_random();
    lat_fixed = 0; lat_rand = 1'b0; rand_ready = 1'b0; man_ready = 1'b1;
    mark();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pixel_valid && pix_addr == 8'd2) begin found = 1'b1; break; end
    end
    man_ready = 1'b0;
    held = out_data;
    checks++; if (!found) begin errors++; $display("FAIL bp_reach_pix2: got timeout want pixel 2"); end
    checks++; if (held !== model_pix(2)) begin errors++; $display("FAIL bp_pix2_value: got %h want %h", held, model_pix(2)); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) man_ready = 1'b1;
      #2;
      if (pixel_valid !== 1'b1 || pix_addr !== 8'd2 || out_data !== held) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
    wait_done(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_done: got timeout want done pulse"); end
    checks++; if (x_addr.size() - xb != NP || frame_bad() != 0) begin
      errors++; $display("FAIL bp_stream: got %0d transfers %0d bad want %0d 0", x_addr.size() - xb, frame_bad(), NP);
    end
    checks++; if (hold_breaks != hb) begin errors++; $display("FAIL bp_hold_monitor: got %0d breaks want 0", hold_breaks - hb); end
    $display("backpressure: pixel 2 held 5 cycles, %0d transfers", x_addr.size() - xb);
  endtask

  task automatic test_slow_storage();
    bit ok;
    int bad;
    fill_random();
    lat_fixed = 3; lat_rand = 1'b0; rand_ready = 1'b0; man_ready = 1'b1;
    mark();
    pulse_start();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      #2;
      if (word_req !== 1'b1 || word_addr !== 6'd0 || pixel_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    #2;
    checks++; if (bad != 0) begin errors++; $display("FAIL slow_wait: got %0d bad REQ cycles want 0", bad); end
    checks++; if (pixel_valid !== 1'b1 || pix_addr !== 8'd0 || out_data !== model_pix(0)) begin
      errors++; $display("FAIL slow_first_pix: pv=%b addr=%0d data=%h want 1 0 %h", pixel_valid, pix_addr, out_data, model_pix(0));
    end
    wait_done(4000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL slow_done: got timeout want done pulse"); end
    checks++; if (x_addr.size() - xb != NP || frame_bad() != 0 || acc_addr.size() - ab != NW) begin
      errors++; $display("FAIL slow_stream: got %0d transfers %0d bad %0d words want %0d 0 %0d", x_addr.size() - xb, frame_bad(), acc_addr.size() - ab, NP, NW);
    end
    lat_fixed = 0;
    $display("slow_storage: latency 3, %0d transfers", x_addr.size() - xb);
  endtask

  task automatic test_reset_mid_frame();
    bit ok, found;
    fill_random();
    lat_rand = 1'b1; rand_ready = 1'b1;
    mark();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (pixel_valid && pix_addr == 8'd97) begin found = 1'b1; break; end
    end
    rst_n = 1'b0;
    rand_ready = 1'b0; man_ready = 1'b1;
    #2;
    checks++; if (!found) begin errors++; $display("FAIL rst_reach_pix97: got timeout want pixel 97"); end
    checks++; if (word_req !== 1'b0 || word_addr !== '0 || pixel_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_ctrl: word_req=%b addr=%0d pv=%b want 0 0 0", word_req, word_addr, pixel_valid);
    end
    checks++; if (pix_addr !== 8'd0 || out_data !== 8'd0 || done !== 1'b0) begin
      errors++; $display("FAIL rst_mid_data: pix_addr=%0d data=%h done=%b want 0 00 0", pix_addr, out_data, done);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    checks++; if (done_count != db || word_req !== 1'b0) begin
      errors++; $display("FAIL rst_no_done: done pulses=%0d word_req=%b want 0 0", done_count - db, word_req);
    end
    rand_ready = 1'b1;
    mark();
    pulse_start();
    wait_done(4000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_restart_done: got timeout want done pulse"); end
    checks++; if (acc_addr.size() <= ab || acc_addr[ab] != 0) begin
      errors++; $display("FAIL rst_restart_word0: got %0d want 0", acc_addr.size() > ab ? acc_addr[ab] : -1);
    end
    checks++; if (x_addr.size() - xb != NP || frame_bad() != 0 || done_count - db != 1) begin
      errors++; $display("FAIL rst_restart_stream: got %0d transfers %0d bad %0d dones want %0d 0 1", x_addr.size() - xb, frame_bad(), done_count - db, NP);
    end
    rand_ready = 1'b0; lat_rand = 1'b0;
    $display("reset_mid_frame: aborted at pixel 97, restarted frame of %0d transfers", x_addr.size() - xb);
  endtask

  task automatic test_spurious();
    bit found_emit, found_done;
    fill_random();
    lat_fixed = 0; lat_rand = 1'b0; rand_ready = 1'b0; man_ready = 1'b1;
    mark();
    pulse_start();
    found_emit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pixel_valid && pix_addr == 8'd10) begin found_emit = 1'b1; break; end
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found_done = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin found_done = 1'b1; break; end
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    spur_valid = 1'b1;
    #2;
    checks++; if (!found_emit || !found_done) begin
      errors++; $display("FAIL spur_reach: emit=%b done=%b want 1 1", found_emit, found_done);
    end
    checks++; if (word_req !== 1'b0) begin errors++; $display("FAIL spur_start_in_done: word_req=%b want 0", word_req); end
    @(negedge clk);
    spur_valid = 1'b0;
    #2;
    checks++; if (word_req !== 1'b0 || pixel_valid !== 1'b0) begin
      errors++; $display("FAIL spur_valid_in_idle: word_req=%b pv=%b want 0 0", word_req, pixel_valid);
    end
    checks++; if (x_addr.size() - xb != NP || frame_bad() != 0 || acc_addr.size() - ab != NW || done_count - db != 1) begin
      errors++; $display("FAIL spur_stream: got %0d transfers %0d bad %0d words %0d dones want %0d 0 %0d 1", x_addr.size() - xb, frame_bad(), acc_addr.size() - ab, done_count - db, NP, NW);
    end
    $display("spurious: start in EMIT/DONE and word_valid in IDLE ignored");
  endtask

  task automatic test_random_frames();
    bit ok;
    for (int f = 0; f < 2; f++) begin
      fill_random();
      lat_rand = 1'b1; rand_ready = 1'b1;
      mark();
      pulse_start();
      wait_done(5000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand%0d_done: got timeout want done pulse", f); end
      checks++; if (x_addr.size() - xb != NP || frame_bad() != 0 || acc_addr.size() - ab != NW) begin
        errors++; $display("FAIL rand%0d_stream: got %0d transfers %0d bad %0d words want %0d 0 %0d", f, x_addr.size() - xb, frame_bad(), acc_addr.size() - ab, NP, NW);
      end
      checks++; if (hold_breaks != hb) begin errors++; $display("FAIL rand%0d_hold: got %0d breaks want 0", f, hold_breaks - hb); end
      $display("random_frame %0d: %0d transfers under random ready and latency", f, x_addr.size() - xb);
    end
    rand_ready = 1'b0; lat_rand = 1'b0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_full_frame();
    test_backpressure();
    test_slow_storage();
    test_reset_mid_frame();
    test_spurious();
    test_random_frames();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/unpack.md
UNPACK -- requirements
Module: unpack

Interface
REQ-001 Parameter NUM_PIX, default 182, SHALL set the number of 8-bit pixels per frame (legal 1..256).
REQ-002 Parameter WORD_AW, default 6, SHALL set the word_addr width, wide enough for ceil(NUM_PIX/4) words.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  in  1  SHALL be a one-cycle request to begin unpacking a frame; it is honoured only in IDLE.
REQ-006 word_req  out  1  SHALL request the 32-bit word at word_addr from storage.
REQ-007 word_addr  out  WORD_AW  SHALL be the index of the requested word.
REQ-008 word_valid  in  1  SHALL indicate that word_data holds the requested word.
REQ-009 word_data  in  32  SHALL be the packed word: byte0 in [7:0], byte1 in [15:8], byte2 in [23:16], byte3 in [31:24].
REQ-010 pixel_valid  out  1  SHALL indicate that out_data and pix_addr hold a pixel.
REQ-011 pix_ready  in  1  SHALL indicate that the consumer accepts the pixel this cycle.
REQ-012 pix_addr  out  8  SHALL be the frame index (0..NUM_PIX-1) of the presented pixel.
REQ-013 out_data  out  8  SHALL be the presented pixel.
REQ-014 done  out  1  SHALL pulse for one cycle when the frame completes.

Function
REQ-015 The FSM SHALL have four states: IDLE, REQ, EMIT and DONE.
REQ-016 IDLE -> REQ SHALL occur on start; start SHALL be ignored in all other states.
REQ-017 In REQ, word_req SHALL be 1 and word_addr SHALL be stable until word_valid is sampled high; the word is accepted on that cycle.
REQ-018 On word acceptance, word_data SHALL be registered, the FSM SHALL enter EMIT, and pixel_valid SHALL rise on the next cycle (1-cycle latency).
REQ-019 A word_valid seen outside REQ SHALL be ignored.
REQ-020 In EMIT, bytes SHALL be presented in order byte0, byte1, byte2, byte3, using a 2-bit byte counter.
REQ-021 A pixel transfer SHALL occur when pixel_valid and pix_ready are both 1.
REQ-022 While pixel_valid=1 and pix_ready=0, out_data and pix_addr SHALL hold stable.
REQ-023 After each transfer, pix_addr SHALL increment by 1 and the byte counter SHALL advance.
REQ-024 A transfer of byte3 (not the final pixel) SHALL cause the next cycle to be in REQ with word_addr+1 and pixel_valid=0; there is no prefetch.
REQ-025 A transfer of pixel NUM_PIX-1 SHALL enter DONE regardless of byte position.
- NUM_PIX=182: the last word (addr 45) supplies only byte0 and byte1 (pix 180, 181); byte2 and byte3 are discarded.
REQ-026 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-027 A start coincident with the done cycle SHALL be ignored.
REQ-028 Throughput SHALL be 4 pixels per word plus 1 REQ cycle, when word_valid returns on the first REQ cycle and pix_ready is held high.

Reset
REQ-029 While rst_n=0, the block SHALL force: state IDLE, word_req=0, word_addr=0, pixel_valid=0, pix_addr=0, out_data=0, done=0, byte counter=0, and the word register=0.
REQ-030 Reset assertion mid-frame SHALL abort immediately, with no done pulse; the next frame requires a new start and restarts from word 0 and pixel 0.

Verification
REQ-031 Basic unpack:
- Stimulus: start; word0=0x44332211 returned on the first REQ cycle; pix_ready=1.
- Response: pixels 0x11, 0x22, 0x33, 0x44 at pix_addr 0..3 on consecutive cycles; word_req for addr 1 on the following cycle.
REQ-032 Full frame:
- Stimulus: NUM_PIX=182, words = incrementing byte pattern, pix_ready=1.
- Response: exactly 182 transfers, pix_addr 0..181; last word_addr=45; done pulses once, one cycle after the pix 181 transfer; no transfer with pix_addr 182.
REQ-033 Backpressure:
- Stimulus: pix_ready=0 for 5 cycles while pixel 2 is presented.
- Response: out_data and pix_addr=2 hold stable; no skipped or duplicated pixel after pix_ready returns to 1.
REQ-034 Slow storage:
- Stimulus: word_valid delayed 3 cycles in REQ.
- Response: word_req stays 1, word_addr stays constant, pixel_valid stays 0 until acceptance.
REQ-035 Reset mid-frame:
- Stimulus: rst_n=0 at pix_addr 97, then restart.
- Response: all outputs reset immediately; the new frame starts at word_addr 0, pix_addr 0; no done pulse from the aborted frame.
REQ-036 Spurious inputs:
- Stimulus: start pulsed during EMIT and during DONE; word_valid pulsed in IDLE.
- Response: no state change, no extra word_req.
